score_arbiter: RTL and testbench

SCORE_ARBITER -- requirements
Module: score_arbiter

---
 rtl/score_arbiter_if.sv | 27 ++
 rtl/score_arbiter.sv | 157 +++++++++++++++
 tb/tb_score_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_arbiter_if.sv
// Bundle of the score arbiter's game-control inputs, request/grant handshake and score outputs.
// The design side uses the slave modport; whoever drives frames and requests uses master.
interface score_arbiter_if;
   logic       frame_tick;
   logic       start;
   logic       pause;
   logic       clear;
   logic [3:0] req;
   logic [3:0] ack;
   logic [3:0] score_hund;
   logic [3:0] score_tens;
   logic [3:0] score_ones;
   logic [7:0] bounce;
   logic [1:0] lives;
   logic [1:0] state;
   logic       game_over;

   modport master (
      output frame_tick, start, pause, clear, req,
      input  ack, score_hund, score_tens, score_ones, bounce, lives, state, game_over
   );

   modport slave (
      input  frame_tick, start, pause, clear, req,
      output ack, score_hund, score_tens, score_ones, bounce, lives, state, game_over
   );
endinterface

// File: rtl/score_arbiter.sv
// Round-robin event arbiter for a game: one grant per frame_tick while playing, BCD score,
// bounce counter, lives and a four-state game FSM. Grants are decided on the tick edge and applied one edge later.
module score_arbiter (
   input  logic           Clk,
   input  logic           Reset,
   score_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      PAUSE = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t     cur_state;
   state_t     next_state;

   logic [1:0] rr_ptr;
   logic       pend_valid;
   logic [1:0] pend_idx;
   logic [3:0] ack_q;
   logic [3:0] hund_q;
   logic [3:0] tens_q;
   logic [3:0] ones_q;
   logic [7:0] bounce_q;
   logic [1:0] lives_q;

   logic [3:0] busy_mask;
   logic [3:0] eligible;
   logic [1:0] cand;
   logic       found;
   logic [1:0] grant_idx;
   logic       hit_ends;
   logic       do_grant;

   logic [3:0] ones_add;
   logic [3:0] tens_add;
   logic [4:0] ones_sum;
   logic [4:0] tens_sum;
   logic       carry_o;
   logic       carry_t;
   logic [3:0] hund_n;
   logic [3:0] tens_n;
   logic [3:0] ones_n;

   // A requester still sees its req high while its grant is in flight or being acked, so mask it out
   always_comb begin
      busy_mask = ack_q;
      if (pend_valid) begin
         busy_mask = busy_mask | (4'b0001 << pend_idx);
      end
      eligible  = bus.req & ~busy_mask;
      found     = 1'b0;
      grant_idx = rr_ptr;
      cand      = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!found && eligible[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      hit_ends = pend_valid && (pend_idx == 2'd3) && (lives_q == 2'd1);
      do_grant = bus.frame_tick && !bus.clear && (cur_state == PLAY) && !hit_ends && found;
   end

   always_comb begin
      next_state = cur_state;
      if (bus.clear) begin
         next_state = IDLE;
      end else if (hit_ends) begin
         next_state = OVER;
      end else begin
         case (cur_state)
            IDLE:    if (bus.start) next_state = PLAY;
            PLAY:    if (bus.pause) next_state = PAUSE;
            PAUSE:   if (bus.start && !bus.pause) next_state = PLAY;
            default: next_state = OVER;
         endcase
      end
   end

   // Decimal add of 1, 5 or 10 with carry between digits; a carry out of hundreds pins the score at 999
   always_comb begin
      ones_add = 4'd0;
      tens_add = 4'd0;
      case (pend_idx)
         2'd0:    ones_add = 4'd1;
         2'd1:    ones_add = 4'd5;
         2'd2:    tens_add = 4'd1;
         default: ones_add = 4'd0;
      endcase
      ones_sum = {1'b0, ones_q} + {1'b0, ones_add};
      carry_o  = (ones_sum > 5'd9);
      ones_n   = carry_o ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
      tens_sum = {1'b0, tens_q} + {1'b0, tens_add} + {4'b0000, carry_o};
      carry_t  = (tens_sum > 5'd9);
      tens_n   = carry_t ? 4'(tens_sum - 5'd10) : tens_sum[3:0];
      hund_n   = hund_q + {3'b000, carry_t};
      if (carry_t && (hund_q == 4'd9)) begin
         hund_n = 4'd9;
         tens_n = 4'd9;
         ones_n = 4'd9;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset || bus.clear) begin
         rr_ptr     <= 2'd0;
         pend_valid <= 1'b0;
         pend_idx   <= 2'd0;
         ack_q      <= 4'b0000;
         hund_q     <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
         bounce_q   <= 8'd0;
         lives_q    <= 2'd3;
      end else begin
         ack_q <= pend_valid ? (4'b0001 << pend_idx) : 4'b0000;
         if (pend_valid) begin
            hund_q <= hund_n;
            tens_q <= tens_n;
            ones_q <= ones_n;
            if (pend_idx == 2'd0) begin
               bounce_q <= bounce_q + 8'd1;
            end
            if (pend_idx == 2'd3) begin
               lives_q <= lives_q - 2'd1;
            end
         end
         pend_valid <= do_grant;
         if (do_grant) begin
            pend_idx <= grant_idx;
            rr_ptr   <= grant_idx + 2'd1;
         end
      end
   end

   assign bus.ack        = ack_q;
   assign bus.score_hund = hund_q;
   assign bus.score_tens = tens_q;
   assign bus.score_ones = ones_q;
   assign bus.bounce     = bounce_q;
   assign bus.lives      = lives_q;
   assign bus.state      = cur_state;
   assign bus.game_over  = (cur_state == OVER);

endmodule

// File: tb/tb_score_arbiter.sv
// Self-checking bench for score_arbiter: directed game scenarios followed by randomized play,
// all compared against a transaction-level game model kept here.
module tb_score_arbiter;

   localparam int S_IDLE  = 0;
   localparam int S_PLAY  = 1;
   localparam int S_PAUSE = 2;
   localparam int S_OVER  = 3;

   logic Clk = 1'b0;
   logic Reset;

   score_arbiter_if bus ();

   score_arbiter dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int         passCount  = 0;
   int         checkCount = 0;
   int         mScore;
   int         mBounce;
   int         mLives;
   int         mState;
   int         mRr;
   logic [3:0] lastAck;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int obsScore();
      return int'({bus.score_hund, bus.score_tens, bus.score_ones});
   endfunction

   function automatic int bcdOf(input int value);
      return ((value / 100) << 8) | (((value / 10) % 10) << 4) | (value % 10);
   endfunction

   function automatic void modelClear();
      mScore  = 0;
      mBounce = 0;
      mLives  = 3;
      mState  = S_IDLE;
      mRr     = 0;
   endfunction

   // Game rules at event level: pick the requester, then apply its effect on score, bounce and lives
   function automatic int modelGrant(input logic [3:0] r);
      int g;
      g = -1;
      if (mState == S_PLAY) begin
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (mRr + k) % 4;
            if (g < 0 && r[i]) g = i;
         end
      end
      if (g >= 0) begin
         mRr = (g + 1) % 4;
         case (g)
            0: begin
               mScore  = (mScore + 1 > 999) ? 999 : mScore + 1;
               mBounce = (mBounce + 1) % 256;
            end
            1: mScore = (mScore + 5 > 999) ? 999 : mScore + 5;
            2: mScore = (mScore + 10 > 999) ? 999 : mScore + 10;
            default: begin
               mLives = mLives - 1;
               if (mLives == 0) mState = S_OVER;
            end
         endcase
      end
      return g;
   endfunction

   task automatic checkModel(input string tag);
      checkOutput({tag, "_score"}, obsScore(), bcdOf(mScore));
      checkOutput({tag, "_bounce"}, int'(bus.bounce), mBounce);
      checkOutput({tag, "_lives"}, int'(bus.lives), mLives);
      checkOutput({tag, "_state"}, int'(bus.state), mState);
      checkOutput({tag, "_over"}, int'(bus.game_over), (mState == S_OVER) ? 1 : 0);
   endtask

   // One cycle of the level controls, then the model's view of the game state
   task automatic applyStimulus(input logic st, input logic pa, input logic cl);
      bus.start = st;
      bus.pause = pa;
      bus.clear = cl;
      @(posedge Clk); #1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.clear = 1'b0;
      if (cl) begin
         modelClear();
      end else begin
         case (mState)
            S_IDLE:  if (st) mState = S_PLAY;
            S_PLAY:  if (pa) mState = S_PAUSE;
            S_PAUSE: if (st && !pa) mState = S_PLAY;
            default: mState = S_OVER;
         endcase
      end
      checkModel("ctl");
      checkOutput("ctl_ack", int'(bus.ack), 0);
   endtask

   task automatic serveTick(input string tag);
      int         g;
      logic [3:0] expAck;
      g = modelGrant(bus.req);
      expAck = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      checkOutput({tag, "_early"}, int'(bus.ack), 0);
      @(posedge Clk); #1;
      lastAck = bus.ack;
      checkOutput({tag, "_ack"}, int'(bus.ack), int'(expAck));
      checkModel(tag);
      if (g >= 0) bus.req[g] = 1'b0;
      @(posedge Clk); #1;
      checkOutput({tag, "_ackdrop"}, int'(bus.ack), 0);
   endtask

   task automatic resetPulse(input string tag);
      Reset = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      modelClear();
      checkModel(tag);
      checkOutput({tag, "_ack"}, int'(bus.ack), 0);
   endtask

   initial begin
      int g1;
      int g2;
      Reset          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      bus.pause      = 1'b0;
      bus.clear      = 1'b0;
      bus.req        = 4'b0000;
      lastAck        = 4'b0000;
      modelClear();
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 1'b1;
      checkModel("reset");
      checkOutput("reset_ack", int'(bus.ack), 0);

      // V1: single bounce
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.req = 4'b0001;
      serveTick("v1");
      checkOutput("v1_ackval", int'(lastAck), 1);
      checkOutput("v1_scoreval", obsScore(), 'h001);
      checkOutput("v1_bounceval", int'(bus.bounce), 1);

      // V2: all four requesters in rotation, then the pointer is back at 0
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         serveTick("v2");
         checkOutput("v2_order", int'(lastAck), 1 << i);
      end
      checkOutput("v2_scoreval", obsScore(), 'h016);
      checkOutput("v2_livesval", int'(bus.lives), 2);
      bus.req = 4'b1001;
      serveTick("v2_rr");
      checkOutput("v2_rrval", int'(lastAck), 1);
      bus.req = 4'b0000;

      // V3: saturation at 999
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 99; i++) begin
         bus.req = 4'b0100;
         serveTick("v3_fill");
      end
      bus.req = 4'b0010;
      serveTick("v3_fill");
      checkOutput("v3_995", obsScore(), 'h995);
      bus.req = 4'b0010;
      serveTick("v3_coin");
      checkOutput("v3_sat", obsScore(), 'h999);
      bus.req = 4'b0100;
      serveTick("v3_bonus");
      checkOutput("v3_hold", obsScore(), 'h999);

      // V4: last life lost, game frozen until clear
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.req = 4'b1000;
         serveTick("v4_hit");
      end
      checkOutput("v4_lives0", int'(bus.lives), 0);
      checkOutput("v4_overflag", int'(bus.game_over), 1);
      bus.req = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         serveTick("v4_frozen");
         checkOutput("v4_noack", int'(lastAck), 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("v4_cleared", int'(bus.lives), 3);
      bus.req = 4'b0000;

      // V5: requests wait out a pause
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      bus.req = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         serveTick("v5_paused");
         checkOutput("v5_noack", int'(lastAck), 0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      serveTick("v5_resume");
      checkOutput("v5_ackval", int'(lastAck), 2);
      checkOutput("v5_scoreval", obsScore(), 'h005);

      // V6: clear beats a same-cycle tick; reset lands on an in-flight grant
      bus.req        = 4'b0001;
      bus.frame_tick = 1'b1;
      bus.clear      = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      bus.clear      = 1'b0;
      modelClear();
      @(posedge Clk); #1;
      checkOutput("v6_clr_ack", int'(bus.ack), 0);
      checkModel("v6_clr");
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      Reset          = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      modelClear();
      checkOutput("v6_rst_ack", int'(bus.ack), 0);
      checkModel("v6_rst");
      @(posedge Clk); #1;
      checkOutput("v6_rst_ack2", int'(bus.ack), 0);

      // Back-to-back ticks: the second arrives while the first grant is being applied
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.req = 4'b0011;
      g1 = modelGrant(4'b0011);
      g2 = modelGrant(4'b0010);
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
      checkOutput("b2b_first", int'(bus.ack), 1 << g1);
      bus.req[g1] = 1'b0;
      @(posedge Clk); #1;
      checkOutput("b2b_second", int'(bus.ack), 1 << g2);
      checkModel("b2b");
      bus.req[g2] = 1'b0;
      @(posedge Clk); #1;
      checkOutput("b2b_drop", int'(bus.ack), 0);

      // Bounce counter wraps 255 -> 0
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         bus.req = 4'b0001;
         serveTick("wrap");
      end
      checkOutput("wrap_bounce", int'(bus.bounce), 0);
      checkOutput("wrap_score", obsScore(), 'h256);

      // Randomized play
      for (int n = 0; n < 400; n++) begin
         int pick;
         pick = int'($urandom_range(0, 99));
         if (pick < 40) begin
            serveTick("rnd_tick");
         end else if (pick < 62) begin
            bus.req = bus.req | 4'($urandom_range(0, 15));
         end else if (pick < 74) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
         end else if (pick < 81) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
         end else if (pick < 85) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
         end else if (pick < 90) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
         end else if (pick < 92) begin
            resetPulse("rnd_reset");
         end else begin
            @(posedge Clk); #1;
            checkOutput("rnd_idle_ack", int'(bus.ack), 0);
            checkModel("rnd_idle");
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
